mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter FONT_BASE, default 12'h000, start address of the 80-byte hex font.
REQ-002 SHALL have parameter PROG_BASE, default 12'h200, lowest address the CPU may write in RUN.
REQ-003 SHALL have ports, one per line: name  direction  width  meaning.
- clk_in  in  1  single clock; all logic on posedge
- rst_in  in  1  reset, synchronous, active-high
- ld_req  in  1  ROM loader write request
- ld_addr  in  12  loader write address
- ld_wdata  in  8  loader write data
- ld_done  in  1  loader finished (level or pulse)
- ld_gnt  out  1  loader write accepted this cycle
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  12  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  8  CPU read data
- gpu_req  in  1  display sprite-read request
- gpu_addr  in  12  sprite address
- gpu_gnt  out  1  GPU read accepted this cycle
- gpu_rvalid  out  1  GPU read data valid
- gpu_rdata  out  8  GPU read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  12  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data, one cycle after mem_en with mem_we=0
- boot_done  out  1  font and ROM resident; CPU may run

Function
REQ-004 SHALL implement states FONT, LOAD, RUN; reset enters FONT.
REQ-005 FONT: SHALL write font byte i to FONT_BASE+i, one byte per cycle, i = 0..79. All grants SHALL be 0. After i = 79, SHALL go to LOAD, or to RUN if ld_done was latched.
REQ-006 SHALL latch ld_done in a sticky flag in any state. The flag SHALL clear only on reset.
REQ-007 LOAD: ld_gnt SHALL equal ld_req, combinationally in the same cycle. The write SHALL be driven on mem_* in that cycle. cpu_gnt and gpu_gnt SHALL be 0.
REQ-008 LOAD: the first cycle ld_done (or the latched flag) is 1 SHALL move to RUN. A ld_req in that same cycle SHALL still be granted and written.
REQ-009 RUN: ld_gnt SHALL be 0; loader requests SHALL be ignored.
REQ-010 RUN: grants SHALL be combinational from requests, at most one grant per cycle.
REQ-011 RUN arbitration:
- single requester is granted
- both requesting: the one not granted last is granted (round-robin)
- last-granted pointer updates only on a grant; reset value = GPU, so the CPU wins first contention
REQ-012 A CPU write with cpu_addr < PROG_BASE SHALL be granted, but with mem_en = 0. The write is dropped; no rvalid.
REQ-013 A granted read SHALL assert the requester's rvalid exactly 1 cycle later, with rdata = mem_rdata. rvalid SHALL be 1 cycle wide.
REQ-014 A CPU write SHALL never produce cpu_rvalid.
REQ-015 rdata SHALL hold its last value when rvalid = 0.
REQ-016 boot_done SHALL be 1 only in RUN, registered, asserting the first cycle in RUN.
REQ-017 Addresses are 12-bit; the font counter SHALL wrap modulo 4096 if FONT_BASE+i overflows.

Reset
REQ-018 On rst_in, all of these SHALL be 0 on the next edge: grants, rvalids, rdata, mem_*, boot_done, the font counter and the ld_done flag. State SHALL be FONT; pointer SHALL be GPU.
REQ-019 Reset mid-operation SHALL abort any in-flight read (no rvalid the next cycle) and restart the font load from i = 0.

Structure
REQ-020 Package chip8_pkg SHALL hold:
- ADDR_W = 12
- FONT_BYTES = 80
- the state enum
- the 80-byte FONT_DATA constant array (standard CHIP-8 0–F glyphs)
REQ-021 SHALL contain one sub-module, font_rom: a combinational 7-bit index to 8-bit glyph byte lookup from chip8_pkg.
REQ-022 The memory array SHALL be external; the arbiter only drives the single port.

Verification
REQ-023 Reset, then 80 cycles: mem_addr 0x000..0x04F written with 0xF0,0x90,0x90,0x90,0xF0,...; grants all 0 even with all reqs high.
REQ-024 LOAD, ld_req with addr 0x200..0x203, data 0xA2,0x2A,0x60,0x0C, last cycle with ld_done=1 -> all four written, boot_done=1 the next cycle.
REQ-025 RUN, cpu and gpu request continuously -> grants alternate CPU, GPU, CPU...; each read's rvalid comes 1 cycle after its grant with the correct data.
REQ-026 RUN, CPU write 0x55 to 0x1FF -> cpu_gnt=1, mem_en=0; CPU write 0x55 to 0x200 -> mem_we=1; both with no rvalid.
REQ-027 ld_done pulsed during FONT -> FONT completes, then RUN directly, with no LOAD cycle.
REQ-028 rst_in asserted the cycle after a CPU read grant -> no cpu_rvalid; font restarts at address 0x000.

Source files
------------

// File: rtl/chip8_pkg.sv
// chip8_pkg: shared widths, arbiter states and the built-in CHIP-8 hex font
package chip8_pkg;
    localparam int ADDR_W     = 12;
    localparam int FONT_BYTES = 80;
    typedef enum logic [1:0] {ST_FONT, ST_LOAD, ST_RUN} state_t;
    localparam logic [7:0] FONT_DATA [FONT_BYTES] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };
endpackage

// File: rtl/font_rom.sv
// font_rom: combinational glyph byte lookup, zero beyond the 80-byte font
module font_rom
    import chip8_pkg::*;
(
    input  logic [6:0] idx,
    output logic [7:0] data
);
    assign data = (idx < 7'(FONT_BYTES)) ? FONT_DATA[idx] : 8'h00;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: boot sequencer (font copy, ROM load) then CPU/GPU round-robin on one memory port
module mem_arbiter
    import chip8_pkg::*;
#(
    parameter logic [ADDR_W-1:0] FONT_BASE = 12'h000,
    parameter logic [ADDR_W-1:0] PROG_BASE = 12'h200
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_wdata,
    input  logic              ld_done,
    output logic              ld_gnt,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [7:0]        cpu_rdata,
    input  logic              gpu_req,
    input  logic [ADDR_W-1:0] gpu_addr,
    output logic              gpu_gnt,
    output logic              gpu_rvalid,
    output logic [7:0]        gpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              boot_done
);
    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       ptr_q, ptr_d;
    logic       cpu_rv_q, cpu_rv_d;
    logic       gpu_rv_q, gpu_rv_d;
    logic [7:0] cpu_rdata_q, cpu_rdata_d;
    logic [7:0] gpu_rdata_q, gpu_rdata_d;
    logic       boot_done_q, boot_done_d;
    logic [7:0] glyph;

    font_rom u_font (.idx(cnt_q), .data(glyph));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = done_q | ld_done;
        ptr_d     = ptr_q;
        ld_gnt    = 1'b0;
        cpu_gnt   = 1'b0;
        gpu_gnt   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rv_d  = 1'b0;
        gpu_rv_d  = 1'b0;
        if (!rst_in) begin
            case (state_q)
                ST_FONT: begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = FONT_BASE + ADDR_W'(cnt_q);
                    mem_wdata = glyph;
                    cnt_d     = cnt_q + 7'd1;
                    if (cnt_q == 7'(FONT_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = done_d ? ST_RUN : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    ld_gnt    = ld_req;
                    mem_en    = ld_req;
                    mem_we    = ld_req;
                    mem_addr  = ld_addr;
                    mem_wdata = ld_wdata;
                    state_d   = done_d ? ST_RUN : ST_LOAD;
                end
                ST_RUN: begin
                    // ptr_q = 1 means GPU was granted last, so CPU wins a tie
                    cpu_gnt   = cpu_req & (~gpu_req | ptr_q);
                    gpu_gnt   = gpu_req & ~cpu_gnt;
                    ptr_d     = cpu_gnt ? 1'b0 : (gpu_gnt ? 1'b1 : ptr_q);
                    mem_en    = gpu_gnt | (cpu_gnt & ~(cpu_we & (cpu_addr < PROG_BASE)));
                    mem_we    = mem_en & cpu_gnt & cpu_we;
                    mem_addr  = cpu_gnt ? cpu_addr : gpu_addr;
                    mem_wdata = cpu_gnt ? cpu_wdata : '0;
                    cpu_rv_d  = cpu_gnt & ~cpu_we;
                    gpu_rv_d  = gpu_gnt;
                end
                default: state_d = ST_FONT;
            endcase
        end
        boot_done_d = (state_d == ST_RUN);
    end

    assign cpu_rvalid  = cpu_rv_q & ~rst_in;
    assign gpu_rvalid  = gpu_rv_q & ~rst_in;
    assign cpu_rdata   = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign gpu_rdata   = gpu_rvalid ? mem_rdata : gpu_rdata_q;
    assign cpu_rdata_d = cpu_rdata;
    assign gpu_rdata_d = gpu_rdata;
    assign boot_done   = boot_done_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_FONT;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            ptr_q       <= 1'b1;
            cpu_rv_q    <= 1'b0;
            gpu_rv_q    <= 1'b0;
            cpu_rdata_q <= '0;
            gpu_rdata_q <= '0;
            boot_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            ptr_q       <= ptr_d;
            cpu_rv_q    <= cpu_rv_d;
            gpu_rv_q    <= gpu_rv_d;
            cpu_rdata_q <= cpu_rdata_d;
            gpu_rdata_q <= gpu_rdata_d;
            boot_done_q <= boot_done_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven RUN arbitration with read scoreboard plus boot and reset sequences
module tb_mem_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        ld_req = 1'b0, ld_done = 1'b0, ld_gnt;
    logic [11:0] ld_addr = '0;
    logic [7:0]  ld_wdata = '0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_gnt, cpu_rvalid;
    logic [11:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0, cpu_rdata;
    logic        gpu_req = 1'b0, gpu_gnt, gpu_rvalid;
    logic [11:0] gpu_addr = '0;
    logic [7:0]  gpu_rdata;
    logic        mem_en, mem_we, boot_done;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  mem [4096] = '{default: 8'h00};
    logic [7:0]  ref_mem [4096] = '{default: 8'h00};

    localparam logic [7:0] FONT [80] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };
    localparam logic [7:0] PROG [4] = '{8'hA2, 8'h2A, 8'h60, 8'h0C};

    typedef struct packed {
        logic        cr, cw;
        logic [11:0] ca;
        logic [7:0]  cd;
        logic        gr;
        logic [11:0] ga;
        logic        ecg, egg, een, ewe;
    } vec_t;
    typedef struct {logic gpu; logic [7:0] data;} exp_t;

    vec_t       vecs [16];
    exp_t       sb [$];
    int         errors = 0, checks = 0;
    logic [7:0] last_cpu = '0, last_gpu = '0;

    always #5 clk_in = ~clk_in;

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_done(ld_done), .ld_gnt(ld_gnt),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_gnt(gpu_gnt), .gpu_rvalid(gpu_rvalid), .gpu_rdata(gpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .boot_done(boot_done)
    );

    // external single-port memory; read data is scrambled on idle cycles so rdata hold is exercised
    always @(posedge clk_in) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_en && !mem_we) ? mem[mem_addr] : 8'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_font(input int pulse);
        for (int i = 0; i < 80; i++) begin
            if (i > 0) @(negedge clk_in);
            ld_done = (i == pulse);
            #1;
            chk("font_en", {mem_en, mem_we}, 2'b11);
            chk("font_addr", mem_addr, i);
            chk("font_data", mem_wdata, FONT[i]);
            chk("font_gnts", {ld_gnt, cpu_gnt, gpu_gnt}, 0);
            chk("font_boot", boot_done, 0);
            ref_mem[i] = FONT[i];
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(negedge clk_in);
        cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
        gpu_req = v.gr; gpu_addr = v.ga;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rvalid", {cpu_rvalid, gpu_rvalid}, e.gpu ? 2'b01 : 2'b10);
            chk("rdata", e.gpu ? gpu_rdata : cpu_rdata, e.data);
            if (e.gpu) last_gpu = e.data; else last_cpu = e.data;
        end else begin
            chk("no_rvalid", {cpu_rvalid, gpu_rvalid}, 0);
            chk("hold_rdata", {cpu_rdata, gpu_rdata}, {last_cpu, last_gpu});
        end
        chk("grants", {cpu_gnt, gpu_gnt, ld_gnt}, {v.ecg, v.egg, 1'b0});
        chk("mem_en", mem_en, v.een);
        if (v.een) begin
            chk("mem_we", mem_we, v.ewe);
            chk("mem_addr", mem_addr, v.ecg ? v.ca : v.ga);
        end
        if (v.ewe) begin
            chk("mem_wdata", mem_wdata, v.cd);
            ref_mem[v.ca] = v.cd;
        end
        if (v.ecg && !v.cw) sb.push_back('{1'b0, ref_mem[v.ca]});
        if (v.egg) sb.push_back('{1'b1, ref_mem[v.ga]});
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 12'h000, 8'h00, 1'b1, 12'h005, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 12'h001, 8'h00, 1'b1, 12'h005, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 12'h200, 8'h00, 1'b1, 12'h006, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 12'h201, 8'h00, 1'b1, 12'h04F, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 12'h202, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 12'h203, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 12'h00A, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 12'h00B, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 12'h1FF, 8'h55, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 12'h200, 8'h55, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 12'h200, 8'h00, 1'b1, 12'h001, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 12'h200, 8'h00, 1'b1, 12'h002, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 12'h300, 8'hAA, 1'b1, 12'h003, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 12'h1FF, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0};

        cpu_req = 1'b1; gpu_req = 1'b1; ld_req = 1'b1;
        @(negedge clk_in); @(negedge clk_in);
        #1;
        chk("rst_gnts", {ld_gnt, cpu_gnt, gpu_gnt}, 0);
        chk("rst_rvalid", {cpu_rvalid, gpu_rvalid}, 0);
        chk("rst_rdata", {cpu_rdata, gpu_rdata}, 0);
        chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
        chk("rst_boot", boot_done, 0);

        @(negedge clk_in);
        rst_in = 1'b0;
        run_font(-1);

        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            ld_req = 1'b1; ld_addr = 12'h200 + 12'(k); ld_wdata = PROG[k]; ld_done = (k == 3);
            #1;
            chk("load_gnt", {ld_gnt, cpu_gnt, gpu_gnt}, 3'b100);
            chk("load_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, ld_addr, PROG[k]});
            chk("load_boot", boot_done, 0);
            ref_mem[ld_addr] = PROG[k];
        end
        @(negedge clk_in);
        ld_done = 1'b0; cpu_req = 1'b0; gpu_req = 1'b0; ld_req = 1'b1;
        #1;
        chk("run_boot", boot_done, 1);
        chk("run_ld_ignored", {ld_gnt, mem_en}, 0);
        ld_req = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);
        chk("sb_drained", sb.size(), 0);

        @(negedge clk_in);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h000; gpu_req = 1'b0;
        #1;
        chk("abort_gnt", cpu_gnt, 1);
        @(negedge clk_in);
        rst_in = 1'b1; gpu_req = 1'b1; ld_req = 1'b1;
        #1;
        chk("abort_rvalid", {cpu_rvalid, gpu_rvalid}, 0);
        chk("abort_gnts", {ld_gnt, cpu_gnt, gpu_gnt}, 0);
        @(negedge clk_in);
        #1;
        chk("abort_rvalid2", {cpu_rvalid, gpu_rvalid}, 0);
        chk("abort_rdata", {cpu_rdata, gpu_rdata}, 0);
        chk("abort_boot_mem", {boot_done, mem_en}, 0);

        @(negedge clk_in);
        rst_in = 1'b0;
        run_font(-1);
        @(negedge clk_in);
        #1;
        chk("flag_cleared_boot", boot_done, 0);
        chk("flag_cleared_load", {ld_gnt, mem_en, cpu_gnt, gpu_gnt}, 4'b1100);

        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        run_font(10);
        @(negedge clk_in);
        ld_done = 1'b0;
        #1;
        chk("direct_run_boot", boot_done, 1);
        chk("direct_run_gnts", {ld_gnt, cpu_gnt, gpu_gnt}, 3'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
